// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, multi-cycle EX
// stalls with a timeout watchdog, MEM-driven flushes and a saturating stall counter.
module pipe_ctrl #(
    parameter int MULTI_TIMEOUT = 64,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stallreq_i,
    input  logic             ex_stallreq_i,
    input  logic             ex_done_i,
    input  logic             flush_req_i,
    input  logic [31:0]      flush_pc_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic             ex_abort_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int TW = $clog2(MULTI_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(MULTI_TIMEOUT - 1);
    localparam logic [5:0] STALL_MULTI = 6'b001111;
    localparam logic [5:0] STALL_LOAD  = 6'b000111;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD,
        ST_MULTI,
        ST_FLUSH
    } state_t;

    state_t           state_reg, state_next;
    logic [TW-1:0]    timer_reg, timer_next;
    logic [CNT_W-1:0] cnt_reg;

    logic [5:0]  stall_next;
    logic        flush_next;
    logic [31:0] new_pc_next;
    logic        abort_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_RUN;
            timer_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            if (stall_o != 6'b0 && cnt_reg != {CNT_W{1'b1}})
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        stall_next  = 6'b0;
        flush_next  = 1'b0;
        new_pc_next = 32'h0;
        abort_next  = 1'b0;
        case (state_reg)
            ST_RUN, ST_LOAD: begin
                if (flush_req_i) begin
                    flush_next  = 1'b1;
                    new_pc_next = flush_pc_i;
                    state_next  = ST_FLUSH;
                end else if (ex_stallreq_i) begin
                    stall_next = STALL_MULTI;
                    timer_next = '0;
                    state_next = ST_MULTI;
                // in LOAD the load has reached MEM and forwards, so the hazard is masked
                end else if (id_stallreq_i && state_reg == ST_RUN) begin
                    stall_next = STALL_LOAD;
                    state_next = ST_LOAD;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_MULTI: begin
                if (flush_req_i) begin
                    flush_next  = 1'b1;
                    new_pc_next = flush_pc_i;
                    abort_next  = 1'b1;
                    state_next  = ST_FLUSH;
                end else if (ex_done_i) begin
                    state_next = ST_RUN;
                end else if (timer_reg == TIMER_LAST) begin
                    abort_next = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    stall_next = STALL_MULTI;
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Reset gates the combinational outputs so nothing leaks while rst is low.
    assign stall_o     = rst ? stall_next  : 6'b0;
    assign flush_o     = rst ? flush_next  : 1'b0;
    assign new_pc_o    = rst ? new_pc_next : 32'h0;
    assign ex_abort_o  = rst ? abort_next  : 1'b0;
    assign stall_cnt_o = cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a default instance plus a short-timeout, narrow-counter
// instance driven by the same stimulus.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        id_stallreq;
    logic        ex_stallreq;
    logic        ex_done;
    logic        flush_req;
    logic [31:0] flush_pc;

    logic [5:0]  stall_a, stall_b;
    logic        flush_a, flush_b;
    logic [31:0] new_pc_a, new_pc_b;
    logic        abort_a, abort_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int checks = 0;
    int failures = 0;

    pipe_ctrl dut_a (
        .clk          (clk),
        .rst          (rst),
        .id_stallreq_i(id_stallreq),
        .ex_stallreq_i(ex_stallreq),
        .ex_done_i    (ex_done),
        .flush_req_i  (flush_req),
        .flush_pc_i   (flush_pc),
        .stall_o      (stall_a),
        .flush_o      (flush_a),
        .new_pc_o     (new_pc_a),
        .ex_abort_o   (abort_a),
        .stall_cnt_o  (cnt_a)
    );

    pipe_ctrl #(.MULTI_TIMEOUT(8), .CNT_W(4)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .id_stallreq_i(id_stallreq),
        .ex_stallreq_i(ex_stallreq),
        .ex_done_i    (ex_done),
        .flush_req_i  (flush_req),
        .flush_pc_i   (flush_pc),
        .stall_o      (stall_b),
        .flush_o      (flush_b),
        .new_pc_o     (new_pc_b),
        .ex_abort_o   (abort_b),
        .stall_cnt_o  (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic        ex;
        logic        done;
        logic        flush;
        logic [31:0] pc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_abort;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic id, input logic ex, input logic done,
                         input logic fl, input logic [31:0] pc);
        @(negedge clk);
        id_stallreq = id;
        ex_stallreq = ex;
        ex_done     = done;
        flush_req   = fl;
        flush_pc    = pc;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        id_stallreq = 0; ex_stallreq = 0; ex_done = 0; flush_req = 0; flush_pc = 0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_b;
        logic [5:0] e_st;

        // id ex dn fl pc            stall     fl pc            ab cnt
        vecs[0]  = '{0,0,0,0,32'h0,        6'b000000,0,32'h0,        0,16'd0};
        vecs[1]  = '{1,0,0,0,32'h0,        6'b000111,0,32'h0,        0,16'd0};
        vecs[2]  = '{1,0,0,0,32'h0,        6'b000000,0,32'h0,        0,16'd1};
        vecs[3]  = '{0,0,0,0,32'h0,        6'b000000,0,32'h0,        0,16'd1};
        vecs[4]  = '{1,1,0,1,32'h80000100, 6'b000000,1,32'h80000100, 0,16'd1};
        vecs[5]  = '{1,1,0,1,32'h80000200, 6'b000000,0,32'h0,        0,16'd1};
        vecs[6]  = '{1,1,0,0,32'h0,        6'b001111,0,32'h0,        0,16'd1};
        vecs[7]  = '{0,0,0,0,32'h0,        6'b001111,0,32'h0,        0,16'd2};
        vecs[8]  = '{0,0,0,1,32'hBFC00380, 6'b000000,1,32'hBFC00380, 1,16'd3};
        vecs[9]  = '{0,0,0,0,32'h0,        6'b000000,0,32'h0,        0,16'd3};
        vecs[10] = '{1,0,0,0,32'h0,        6'b000111,0,32'h0,        0,16'd3};
        vecs[11] = '{0,1,0,0,32'h0,        6'b001111,0,32'h0,        0,16'd4};
        vecs[12] = '{0,1,1,0,32'h0,        6'b000000,0,32'h0,        0,16'd5};
        vecs[13] = '{1,0,0,0,32'hDEADBEEF, 6'b000111,0,32'h0,        0,16'd5};
        vecs[14] = '{0,0,0,1,32'h00000040, 6'b000000,1,32'h00000040, 0,16'd6};
        vecs[15] = '{0,0,0,0,32'h0,        6'b000000,0,32'h0,        0,16'd6};
        vecs[16] = '{0,0,0,0,32'h0,        6'b000000,0,32'h0,        0,16'd6};

        // T1: reset held with every input high
        rst = 1'b0;
        id_stallreq = 1; ex_stallreq = 1; ex_done = 1; flush_req = 1; flush_pc = 32'h12345678;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {26'b0, stall_a}, 32'h0);
        chk("rst_flush", {31'b0, flush_a}, 32'h0);
        chk("rst_new_pc", new_pc_a, 32'h0);
        chk("rst_abort", {31'b0, abort_a}, 32'h0);
        chk("rst_cnt", {16'b0, cnt_a}, 32'h0);
        $display("reset held: stall=%b flush=%b pc=%h abort=%b", stall_a, flush_a, new_pc_a, abort_a);
        do_reset();

        // T2/T5/T6-priority: table of single-cycle vectors on the default instance
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].id, vecs[i].ex, vecs[i].done, vecs[i].flush, vecs[i].pc);
            $display("vec %0d: stall=%b flush=%b pc=%h abort=%b cnt=%0d",
                     i, stall_a, flush_a, new_pc_a, abort_a, cnt_a);
            chk($sformatf("vec%0d_stall", i), {26'b0, stall_a}, {26'b0, vecs[i].e_stall});
            chk($sformatf("vec%0d_flush", i), {31'b0, flush_a}, {31'b0, vecs[i].e_flush});
            chk($sformatf("vec%0d_pc", i), new_pc_a, vecs[i].e_pc);
            chk($sformatf("vec%0d_abort", i), {31'b0, abort_a}, {31'b0, vecs[i].e_abort});
            chk($sformatf("vec%0d_cnt", i), {16'b0, cnt_a}, {16'b0, vecs[i].e_cnt});
        end

        // T3: ex_stallreq pulse, done after 10 stall cycles (default instance)
        for (int c = 0; c <= 11; c++) begin
            drive(0, c == 0, c == 10, 0, 32'h0);
            e_st = (c < 10) ? 6'b001111 : 6'b000000;
            $display("multi cyc %0d: stall=%b abort=%b", c, stall_a, abort_a);
            chk($sformatf("multi%0d_stall", c), {26'b0, stall_a}, {26'b0, e_st});
            chk($sformatf("multi%0d_abort", c), {31'b0, abort_a}, 32'h0);
        end
        chk("multi_cnt", {16'b0, cnt_a}, 32'd16);

        // T4: timeout on the MULTI_TIMEOUT=8 instance
        for (int c = 0; c <= 9; c++) begin
            drive(0, c == 0, 0, 0, 32'h0);
            e_st = (c < 8) ? 6'b001111 : 6'b000000;
            $display("timeout cyc %0d: stall=%b abort=%b", c, stall_b, abort_b);
            chk($sformatf("tmo%0d_stall", c), {26'b0, stall_b}, {26'b0, e_st});
            chk($sformatf("tmo%0d_abort", c), {31'b0, abort_b}, {31'b0, c == 8});
        end

        // done on the same cycle the timer expires: counts as done, no abort
        for (int c = 0; c <= 9; c++) begin
            drive(0, c == 0, c == 8, 0, 32'h0);
            e_st = (c < 8) ? 6'b001111 : 6'b000000;
            $display("done@tmo cyc %0d: stall=%b abort=%b", c, stall_b, abort_b);
            chk($sformatf("dtmo%0d_stall", c), {26'b0, stall_b}, {26'b0, e_st});
            chk($sformatf("dtmo%0d_abort", c), {31'b0, abort_b}, 32'h0);
        end

        // T6 saturation: 20 load-use stalls (id held, RUN/LOAD alternate)
        do_reset();
        exp_b = 4'd0;
        for (int c = 0; c < 40; c++) begin
            drive(1, 0, 0, 0, 32'h0);
            chk($sformatf("sat%0d_cnt", c), {28'b0, cnt_b}, {28'b0, exp_b});
            chk($sformatf("sat%0d_stall", c), {26'b0, stall_b},
                (c % 2 == 0) ? 32'h7 : 32'h0);
            if (stall_b != 6'b0 && exp_b != 4'hF) exp_b = exp_b + 4'd1;
        end
        drive(0, 0, 0, 0, 32'h0);
        $display("saturation: cnt_b=%h cnt_a=%0d", cnt_b, cnt_a);
        chk("sat_cnt_b", {28'b0, cnt_b}, 32'hF);
        chk("sat_cnt_a", {16'b0, cnt_a}, 32'd20);

        // reset asserted mid-MULTI: immediate return to RUN, no abort pulse
        drive(0, 1, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        chk("midrst_pre_stall", {26'b0, stall_a}, 32'hF);
        rst = 1'b0;
        #1;
        chk("midrst_stall", {26'b0, stall_a}, 32'h0);
        chk("midrst_abort", {31'b0, abort_a}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        $display("after mid-multi reset: stall=%b abort=%b cnt=%0d", stall_a, abort_a, cnt_a);
        chk("postrst_stall", {26'b0, stall_a}, 32'h0);
        chk("postrst_abort", {31'b0, abort_a}, 32'h0);
        chk("postrst_cnt", {16'b0, cnt_a}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
